// File: rtl/slot_credit_ctrl_pkg.sv
// Shared types and default parameter values for the slot-machine credit controller.
// No logic; pure definitions.
// Imported by the controller top.
package slot_credit_ctrl_pkg;

  // Game sequencing states
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SPIN   = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  localparam int DEF_BAL_W        = 11;
  localparam int DEF_BAL_MAX      = 999;
  localparam int DEF_NUM_DENOM    = 3;
  localparam int DEF_MULT_W       = 3;
  localparam int DEF_SPIN_TIMEOUT = 1023;

  // Slice 0 (LSBs) is switch 0: switch 0 = 5, switch 1 = 10, switch 2 = 20 credits
  localparam logic [DEF_NUM_DENOM*DEF_BAL_W-1:0] DEF_DENOM_VALS = {11'd20, 11'd10, 11'd5};

endpackage

// File: rtl/slot_credit_ctrl_btn_edge.sv
// Rising-edge detector for one debounced button level.
// Latency: pulse is registered, one cycle after the level is first seen high.
// No backpressure: a held button yields exactly one pulse.
module slot_credit_ctrl_btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  logic prev;

  // Remember the previous level and flag a low-to-high transition
  always_ff @(posedge clk) begin
    if (reset) begin
      prev  <= 1'b0;
      pulse <= 1'b0;
    end else begin
      prev  <= btn;
      pulse <= btn & ~prev;
    end
  end

endmodule

// File: rtl/slot_credit_ctrl.sv
// Credit/bet controller: balance, invested total, last win, and the bet -> spin -> settle sequence.
// Latency: button edge to action 2 cycles; result_valid to balance update 2 cycles; bet is combinational.
// No backpressure: button edges outside IDLE are dropped; a spin with no result refunds after SPIN_TIMEOUT cycles.
module slot_credit_ctrl
  import slot_credit_ctrl_pkg::*;
#(
  parameter int                            BAL_W        = DEF_BAL_W,
  parameter int                            BAL_MAX      = DEF_BAL_MAX,
  parameter int                            NUM_DENOM    = DEF_NUM_DENOM,
  parameter logic [NUM_DENOM*BAL_W-1:0]    DENOM_VALS   = DEF_DENOM_VALS,
  parameter int                            MULT_W       = DEF_MULT_W,
  parameter int                            SPIN_TIMEOUT = DEF_SPIN_TIMEOUT
) (
  input  logic                 gameClk,
  input  logic                 reset,
  input  logic                 add_btn,
  input  logic                 gamble_btn,
  input  logic                 cash_out_btn,
  input  logic [NUM_DENOM-1:0] denom_sel,
  input  logic                 result_valid,
  input  logic [MULT_W-1:0]    result_mult,
  output logic [BAL_W-1:0]     bet,
  output logic [BAL_W-1:0]     balance,
  output logic [BAL_W-1:0]     invested,
  output logic [BAL_W-1:0]     last_win,
  output logic                 spin_start,
  output logic                 busy,
  output logic                 bet_rejected,
  output logic                 spin_timeout
);

  // Bet sum needs enough headroom that adding every denomination cannot wrap
  localparam int SUM_W  = BAL_W + $clog2(NUM_DENOM + 1);
  localparam int PROD_W = BAL_W + MULT_W;
  localparam int CNT_W  = $clog2(SPIN_TIMEOUT + 1);

  localparam logic [BAL_W-1:0]  MAX_B    = BAL_W'(BAL_MAX);
  localparam logic [BAL_W:0]    MAX_W1   = (BAL_W + 1)'(BAL_MAX);
  localparam logic [SUM_W-1:0]  MAX_SUM  = SUM_W'(BAL_MAX);
  localparam logic [PROD_W-1:0] MAX_PROD = PROD_W'(BAL_MAX);
  // Timeout fires at the end of the SPIN_TIMEOUT-th cycle spent in SPIN
  localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(SPIN_TIMEOUT - 1);

  state_t              state;
  logic [CNT_W-1:0]    spin_cnt;
  logic [BAL_W-1:0]    bet_lat;
  logic [MULT_W-1:0]   mult_lat;

  logic                add_edge;
  logic                gamble_edge;
  logic                cash_edge;

  logic [SUM_W-1:0]    bet_sum;
  logic [PROD_W-1:0]   prod;
  logic [BAL_W-1:0]    win;
  logic [BAL_W-1:0]    bal_addend;
  logic [BAL_W:0]      bal_sum;
  logic [BAL_W-1:0]    bal_sat;
  logic [BAL_W:0]      inv_sum;
  logic [BAL_W-1:0]    inv_sat;

  slot_credit_ctrl_btn_edge u_add_edge (
    .clk   (gameClk),
    .reset (reset),
    .btn   (add_btn),
    .pulse (add_edge)
  );

  slot_credit_ctrl_btn_edge u_gamble_edge (
    .clk   (gameClk),
    .reset (reset),
    .btn   (gamble_btn),
    .pulse (gamble_edge)
  );

  slot_credit_ctrl_btn_edge u_cash_edge (
    .clk   (gameClk),
    .reset (reset),
    .btn   (cash_out_btn),
    .pulse (cash_edge)
  );

  // Sum the credit values of all selected denomination switches
  always_comb begin
    bet_sum = '0;
    for (int i = 0; i < NUM_DENOM; i++) begin
      if (denom_sel[i]) begin
        bet_sum = bet_sum + SUM_W'(DENOM_VALS[i*BAL_W +: BAL_W]);
      end
    end
  end

  assign bet = (bet_sum > MAX_SUM) ? MAX_B : bet_sum[BAL_W-1:0];

  // Payout at full product width, clamped to the ceiling
  assign prod = PROD_W'(bet_lat) * PROD_W'(mult_lat);
  assign win  = (prod > MAX_PROD) ? MAX_B : prod[BAL_W-1:0];

  // One shared saturating adder for the balance: deposit in IDLE, refund in SPIN, payout in SETTLE
  always_comb begin
    case (state)
      S_SPIN:   bal_addend = bet_lat;
      S_SETTLE: bal_addend = win;
      default:  bal_addend = bet;
    endcase
  end

  assign bal_sum = {1'b0, balance} + {1'b0, bal_addend};
  assign bal_sat = (bal_sum > MAX_W1) ? MAX_B : bal_sum[BAL_W-1:0];
  assign inv_sum = {1'b0, invested} + {1'b0, bet};
  assign inv_sat = (inv_sum > MAX_W1) ? MAX_B : inv_sum[BAL_W-1:0];

  assign busy = (state != S_IDLE);

  // Game sequencer: credit registers, spin timer and single-cycle status pulses
  always_ff @(posedge gameClk) begin
    if (reset) begin
      state        <= S_IDLE;
      spin_cnt     <= '0;
      bet_lat      <= '0;
      mult_lat     <= '0;
      balance      <= '0;
      invested     <= '0;
      last_win     <= '0;
      spin_start   <= 1'b0;
      bet_rejected <= 1'b0;
      spin_timeout <= 1'b0;
    end else begin
      spin_start   <= 1'b0;
      bet_rejected <= 1'b0;
      spin_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cash_edge) begin
            balance  <= '0;
            invested <= '0;
          end else if (add_edge) begin
            balance  <= bal_sat;
            invested <= inv_sat;
          end else if (gamble_edge) begin
            if ((bet != '0) && (balance >= bet)) begin
              balance    <= balance - bet;
              bet_lat    <= bet;
              spin_cnt   <= '0;
              spin_start <= 1'b1;
              state      <= S_SPIN;
            end else begin
              bet_rejected <= 1'b1;
            end
          end
        end
        S_SPIN: begin
          if (result_valid) begin
            mult_lat <= result_mult;
            state    <= S_SETTLE;
          end else if (spin_cnt == TO_LAST) begin
            balance      <= bal_sat;
            spin_timeout <= 1'b1;
            state        <= S_IDLE;
          end else begin
            spin_cnt <= spin_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          balance  <= bal_sat;
          last_win <= win;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slot_credit_ctrl.sv
// Self-checking bench for slot_credit_ctrl: directed scenarios with literal expectations,
// then randomized buttons/results compared every cycle against a behavioural model.
// The model works on game rules (edges act one cycle after detection, saturating integer credits).
module tb_slot_credit_ctrl;

  localparam int BAL_MAX_TB = 999;
  localparam int TIMEOUT_TB = 1023;
  localparam int ADD  = 0;
  localparam int GAM  = 1;
  localparam int CASH = 2;
  localparam int PH_IDLE   = 0;
  localparam int PH_SPIN   = 1;
  localparam int PH_SETTLE = 2;

  logic        gameClk = 1'b0;
  logic        reset = 1'b1;
  logic        add_btn = 1'b0;
  logic        gamble_btn = 1'b0;
  logic        cash_out_btn = 1'b0;
  logic [2:0]  denom_sel = 3'b000;
  logic        result_valid = 1'b0;
  logic [2:0]  result_mult = 3'd0;
  logic [10:0] bet;
  logic [10:0] balance;
  logic [10:0] invested;
  logic [10:0] last_win;
  logic        spin_start;
  logic        busy;
  logic        bet_rejected;
  logic        spin_timeout;

  slot_credit_ctrl dut (
    .gameClk      (gameClk),
    .reset        (reset),
    .add_btn      (add_btn),
    .gamble_btn   (gamble_btn),
    .cash_out_btn (cash_out_btn),
    .denom_sel    (denom_sel),
    .result_valid (result_valid),
    .result_mult  (result_mult),
    .bet          (bet),
    .balance      (balance),
    .invested     (invested),
    .last_win     (last_win),
    .spin_start   (spin_start),
    .busy         (busy),
    .bet_rejected (bet_rejected),
    .spin_timeout (spin_timeout)
  );

  always #5 gameClk = ~gameClk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  int m_bal = 0, m_inv = 0, m_win = 0, m_phase = PH_IDLE;
  int m_bet_lat = 0, m_mult = 0, m_spin_cyc = 0;
  int m_ss = 0, m_rej = 0, m_to = 0;
  logic [2:0] m_prev = 3'b000;
  logic [2:0] m_pend = 3'b000;

  // Pulse counters observed on the DUT
  int n_ss = 0, n_rej = 0, n_to = 0;

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > BAL_MAX_TB) ? BAL_MAX_TB : v;
  endfunction

  function automatic int model_bet(input logic [2:0] sel);
    int s;
    s = 0;
    if (sel[0]) s += 5;
    if (sel[1]) s += 10;
    if (sel[2]) s += 20;
    return sat(s);
  endfunction

  // One clock of game rules; button edges seen at the previous clock are acted on now
  task automatic model_step();
    int b;
    int w;
    m_ss = 0; m_rej = 0; m_to = 0;
    if (reset) begin
      m_bal = 0; m_inv = 0; m_win = 0; m_phase = PH_IDLE;
      m_bet_lat = 0; m_mult = 0; m_spin_cyc = 0;
      m_prev = 3'b000; m_pend = 3'b000;
      return;
    end
    b = model_bet(denom_sel);
    if (m_phase == PH_IDLE) begin
      if (m_pend[CASH]) begin
        m_bal = 0; m_inv = 0;
      end else if (m_pend[ADD]) begin
        m_bal = sat(m_bal + b); m_inv = sat(m_inv + b);
      end else if (m_pend[GAM]) begin
        if (b != 0 && m_bal >= b) begin
          m_bal -= b; m_bet_lat = b; m_ss = 1; m_spin_cyc = 0; m_phase = PH_SPIN;
        end else begin
          m_rej = 1;
        end
      end
    end else if (m_phase == PH_SPIN) begin
      m_spin_cyc++;
      if (result_valid) begin
        m_mult = result_mult; m_phase = PH_SETTLE;
      end else if (m_spin_cyc == TIMEOUT_TB) begin
        m_bal = sat(m_bal + m_bet_lat); m_to = 1; m_phase = PH_IDLE;
      end
    end else begin
      w = sat(m_bet_lat * m_mult);
      m_bal = sat(m_bal + w); m_win = w; m_phase = PH_IDLE;
    end
    m_pend = {cash_out_btn, gamble_btn, add_btn} & ~m_prev;
    m_prev = {cash_out_btn, gamble_btn, add_btn};
  endtask

  initial forever begin
    @(posedge gameClk);
    model_step();
  end

  // Compare process: every cycle, on the falling edge
  initial forever begin
    @(negedge gameClk);
    n_ss  += int'(spin_start);
    n_rej += int'(bet_rejected);
    n_to  += int'(spin_timeout);
    if (chk_en) begin
      chk("bet",          int'(bet),          model_bet(denom_sel));
      chk("balance",      int'(balance),      m_bal);
      chk("invested",     int'(invested),     m_inv);
      chk("last_win",     int'(last_win),     m_win);
      chk("spin_start",   int'(spin_start),   m_ss);
      chk("busy",         int'(busy),         int'(m_phase != PH_IDLE));
      chk("bet_rejected", int'(bet_rejected), m_rej);
      chk("spin_timeout", int'(spin_timeout), m_to);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge gameClk);
      #1;
    end
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      ADD:     add_btn = v;
      GAM:     gamble_btn = v;
      default: cash_out_btn = v;
    endcase
  endtask

  task automatic press(input int which);
    set_btn(which, 1'b1);
    step(1);
    set_btn(which, 1'b0);
    step(3);
  endtask

  int r0, s0, t0;

  initial begin
    // Reset state
    step(1);
    chk_en = 1'b1;
    chk("rst_balance", int'(balance), 0);
    chk("rst_invested", int'(invested), 0);
    chk("rst_last_win", int'(last_win), 0);
    chk("rst_busy", int'(busy), 0);
    step(1);
    reset = 1'b0;
    step(1);

    // Deposits, and a held button acting once
    denom_sel = 3'b011;
    press(ADD);
    press(ADD);
    chk("dep2_balance", int'(balance), 30);
    chk("dep2_invested", int'(invested), 30);
    add_btn = 1'b1;
    step(10);
    add_btn = 1'b0;
    step(2);
    chk("held_balance", int'(balance), 45);
    chk("held_invested", int'(invested), 45);

    // Cash out, redeposit, then an unaffordable bet
    press(CASH);
    chk("cash_balance", int'(balance), 0);
    press(ADD);
    press(ADD);
    denom_sel = 3'b111;
    step(1);
    chk("bet_all", int'(bet), 35);
    r0 = n_rej; s0 = n_ss;
    press(GAM);
    chk("rej_pulse", n_rej - r0, 1);
    chk("rej_no_spin", n_ss - s0, 0);
    chk("rej_balance", int'(balance), 30);

    // Accepted bet with exact latencies
    denom_sel = 3'b011;
    step(1);
    gamble_btn = 1'b1;
    step(1);
    chk("lat_gamble_1", int'(spin_start), 0);
    gamble_btn = 1'b0;
    step(1);
    chk("lat_gamble_2", int'(spin_start), 1);
    chk("spin_busy", int'(busy), 1);
    chk("spin_balance", int'(balance), 15);
    step(2);
    result_mult = 3'd3;
    result_valid = 1'b1;
    step(1);
    result_valid = 1'b0;
    chk("settle_busy", int'(busy), 1);
    chk("settle_bal_hold", int'(balance), 15);
    step(1);
    chk("win_balance", int'(balance), 60);
    chk("win_last", int'(last_win), 45);
    chk("win_idle", int'(busy), 0);

    // Saturation of deposits and payout
    press(CASH);
    chk("cash_keeps_win", int'(last_win), 45);
    denom_sel = 3'b111;
    repeat (28) press(ADD);
    denom_sel = 3'b010;
    press(ADD);
    chk("bal_990", int'(balance), 990);
    denom_sel = 3'b001;
    press(ADD);
    chk("bal_995", int'(balance), 995);
    press(ADD);
    chk("bal_sat", int'(balance), 999);
    chk("inv_sat", int'(invested), 999);
    denom_sel = 3'b100;
    step(1);
    press(GAM);
    chk("bet20_balance", int'(balance), 979);
    result_mult = 3'd7;
    result_valid = 1'b1;
    step(1);
    result_valid = 1'b0;
    step(2);
    chk("pay_sat_balance", int'(balance), 999);
    chk("pay_last_win", int'(last_win), 140);

    // Timeout with refund
    t0 = n_to;
    gamble_btn = 1'b1;
    step(1);
    gamble_btn = 1'b0;
    step(1);
    chk("to_start", int'(spin_start), 1);
    step(TIMEOUT_TB - 1);
    chk("to_still_busy", int'(busy), 1);
    chk("to_no_refund_yet", int'(balance), 979);
    step(1);
    chk("to_pulse", int'(spin_timeout), 1);
    chk("to_idle", int'(busy), 0);
    chk("to_refund", int'(balance), 999);
    step(1);
    chk("to_pulse_count", n_to - t0, 1);

    // Result on the timeout cycle wins; multiplier 0 pays nothing
    gamble_btn = 1'b1;
    step(1);
    gamble_btn = 1'b0;
    step(1);
    step(TIMEOUT_TB - 1);
    result_mult = 3'd0;
    result_valid = 1'b1;
    step(1);
    result_valid = 1'b0;
    chk("race_settle", int'(busy), 1);
    chk("race_no_timeout", n_to - t0, 1);
    step(1);
    chk("mult0_win", int'(last_win), 0);
    chk("mult0_balance", int'(balance), 979);

    // Reset during a spin abandons it
    gamble_btn = 1'b1;
    step(1);
    gamble_btn = 1'b0;
    step(5);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midrst_balance", int'(balance), 0);
    chk("midrst_busy", int'(busy), 0);
    result_mult = 3'd5;
    result_valid = 1'b1;
    step(1);
    result_valid = 1'b0;
    step(2);
    chk("midrst_ignore_bal", int'(balance), 0);
    chk("midrst_ignore_win", int'(last_win), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3, 0) == 0) add_btn = ~add_btn;
      if ($urandom_range(4, 0) == 0) gamble_btn = ~gamble_btn;
      if ($urandom_range(19, 0) == 0) cash_out_btn = ~cash_out_btn;
      if ($urandom_range(15, 0) == 0) denom_sel = 3'($urandom_range(7, 0));
      result_valid = ($urandom_range(5, 0) == 0);
      result_mult = 3'($urandom_range(7, 0));
      reset = ($urandom_range(699, 0) == 0);
      step(1);
    end
    add_btn = 1'b0;
    gamble_btn = 1'b0;
    cash_out_btn = 1'b0;
    result_valid = 1'b0;
    reset = 1'b0;
    step(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
